// File: rtl/txdsp_quant_if.sv
// Sample bus for txdsp_quant: 16-bit I/Q inputs in, 12-bit DAC words out.
interface txdsp_quant_if;
  logic [15:0] in_ai;
  logic [15:0] in_aq;
  logic [15:0] in_bi;
  logic [15:0] in_bq;
  logic        in_valid;
  logic        in_last;
  logic [11:0] out_ai;
  logic [11:0] out_aq;
  logic [11:0] out_bi;
  logic [11:0] out_bq;
  logic        out_valid;
  logic        out_last;

  // Sample source / DAC sink side
  modport master (
    output in_ai, in_aq, in_bi, in_bq, in_valid, in_last,
    input  out_ai, out_aq, out_bi, out_bq, out_valid, out_last
  );

  // Conditioner side
  modport slave (
    input  in_ai, in_aq, in_bi, in_bq, in_valid, in_last,
    output out_ai, out_aq, out_bi, out_bq, out_valid, out_last
  );
endinterface

// File: rtl/txdsp_quant.sv
// TX sample conditioner: IQ swap, Q negation and 12-bit quantisation for two
// channels, fixed 2-cycle pipeline, config changes applied at packet boundaries.
module txdsp_quant #(
  parameter int unsigned CLIP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dspcmd_valid,
  input  logic [27:0]           dspcmd_data,
  input  logic [1:0]            dspcmd_legacy,
  txdsp_quant_if.slave          bus,
  output logic [CLIP_CNT_W-1:0] clip_cnt,
  output logic                  clip_flag
);

  // Member order matches dspcmd_data[3:0] so the command loads directly.
  typedef struct packed {
    logic       neg;
    logic       swap;
    logic [1:0] mode;
  } cfg_t;

  typedef enum logic {IDLE, BURST} state_t;

  state_t state, state_nxt;
  logic   cfg_load;
  cfg_t   shadow_cfg, active_cfg, eff_cfg;

  logic clr_clip;
  logic unused_cmd_bits;

  logic [15:0] l_ai, l_aq, l_bi, l_bq;
  logic [16:0] n_ai, n_aq, n_bi, n_bq;

  logic signed [16:0] s1_ai, s1_aq, s1_bi, s1_bq;
  logic [1:0]         s1_mode;
  logic               s1_valid, s1_last;

  logic [12:0] q_ai, q_aq, q_bi, q_bq;
  logic        out_clip;

  assign clr_clip        = dspcmd_valid & dspcmd_data[4];
  assign unused_cmd_bits = ^dspcmd_data[27:5];

  function automatic logic [12:0] sat12(input logic signed [17:0] v);
    if (v > 18'sd2047)
      return {1'b1, 12'h7FF};
    else if (v < -18'sd2048)
      return {1'b1, 12'h800};
    else
      return {1'b0, v[11:0]};
  endfunction

  // Returns {clip, word}.
  function automatic logic [12:0] quant(input logic signed [16:0] x, input logic [1:0] mode);
    logic signed [17:0] w;
    logic signed [17:0] r;
    w = {x[16], x};
    r = w + 18'sd8;
    case (mode)
      2'd0:    return {1'b0, x[15:4]};
      2'd1:    return sat12(r >>> 4);
      2'd2:    return sat12(w);
      default: return 13'd0;
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and config-load point
  always_comb begin
    state_nxt = state;
    cfg_load  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_last) cfg_load  = 1'b1;
          else             state_nxt = BURST;
        end else begin
          cfg_load = 1'b1;
        end
      end
      BURST: begin
        if (bus.in_valid && bus.in_last) begin
          state_nxt = IDLE;
          cfg_load  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow takes every command; active picks up the pre-edge shadow at load points
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_cfg <= '0;
      active_cfg <= '0;
    end else begin
      if (dspcmd_valid) shadow_cfg <= cfg_t'(dspcmd_data[3:0]);
      if (cfg_load)     active_cfg <= shadow_cfg;
    end
  end

  // Effective config plus lane swap and Q negation in 17 bits
  always_comb begin
    eff_cfg = active_cfg;
    if (dspcmd_legacy != 2'b00) begin
      eff_cfg.mode = 2'd2;
      eff_cfg.swap = 1'b0;
      eff_cfg.neg  = 1'b0;
    end
    l_ai = eff_cfg.swap ? bus.in_aq : bus.in_ai;
    l_aq = eff_cfg.swap ? bus.in_ai : bus.in_aq;
    l_bi = eff_cfg.swap ? bus.in_bq : bus.in_bi;
    l_bq = eff_cfg.swap ? bus.in_bi : bus.in_bq;
    n_ai = {l_ai[15], l_ai};
    n_bi = {l_bi[15], l_bi};
    n_aq = eff_cfg.neg ? (17'd0 - {l_aq[15], l_aq}) : {l_aq[15], l_aq};
    n_bq = eff_cfg.neg ? (17'd0 - {l_bq[15], l_bq}) : {l_bq[15], l_bq};
  end

  // Stage 1: register conditioned lanes with the mode they were accepted under
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= '0;
      s1_ai    <= '0;
      s1_aq    <= '0;
      s1_bi    <= '0;
      s1_bq    <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      s1_last  <= bus.in_valid & bus.in_last;
      if (bus.in_valid) begin
        s1_mode <= eff_cfg.mode;
        s1_ai   <= n_ai;
        s1_aq   <= n_aq;
        s1_bi   <= n_bi;
        s1_bq   <= n_bq;
      end
    end
  end

  // Quantisation of the stage-1 lanes
  always_comb begin
    q_ai = quant(s1_ai, s1_mode);
    q_aq = quant(s1_aq, s1_mode);
    q_bi = quant(s1_bi, s1_mode);
    q_bq = quant(s1_bq, s1_mode);
  end

  // Stage 2: output words hold while no valid sample arrives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      out_clip      <= 1'b0;
      bus.out_ai    <= '0;
      bus.out_aq    <= '0;
      bus.out_bi    <= '0;
      bus.out_bq    <= '0;
    end else begin
      bus.out_valid <= s1_valid;
      bus.out_last  <= s1_valid & s1_last;
      out_clip      <= s1_valid & (q_ai[12] | q_aq[12] | q_bi[12] | q_bq[12]);
      if (s1_valid) begin
        bus.out_ai <= q_ai[11:0];
        bus.out_aq <= q_aq[11:0];
        bus.out_bi <= q_bi[11:0];
        bus.out_bq <= q_bq[11:0];
      end
    end
  end

  // Clip accounting on output samples; a clear command wins over a same-cycle event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_cnt  <= '0;
      clip_flag <= 1'b0;
    end else if (clr_clip) begin
      clip_cnt  <= '0;
      clip_flag <= 1'b0;
    end else if (bus.out_valid && out_clip) begin
      if (clip_cnt != '1) clip_cnt <= clip_cnt + 1'b1;
      clip_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_txdsp_quant.sv
// Self-checking bench for txdsp_quant: directed scenarios plus randomized bursts
// compared against an arithmetic reference model.
module tb_txdsp_quant;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          dspcmd_valid;
  logic [27:0]   dspcmd_data;
  logic [1:0]    dspcmd_legacy;
  logic [CW-1:0] clip_cnt;
  logic          clip_flag;

  txdsp_quant_if bus();

  txdsp_quant #(.CLIP_CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .dspcmd_valid (dspcmd_valid),
    .dspcmd_data  (dspcmd_data),
    .dspcmd_legacy(dspcmd_legacy),
    .bus          (bus),
    .clip_cnt     (clip_cnt),
    .clip_flag    (clip_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: config words, burst flag, and expected results in flight
  int m_shadow, m_active;
  bit m_burst;
  bit p1_v, p1_l, p1_c;
  int p1_d[4];
  bit p2_v, p2_l, p2_c;
  int p2_d[4];
  int m_cnt;
  bit m_flag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_shadow = 0; m_active = 0; m_burst = 0;
    p1_v = 0; p1_l = 0; p1_c = 0;
    p2_v = 0; p2_l = 0; p2_c = 0;
    for (int i = 0; i < 4; i++) begin
      p1_d[i] = 0;
      p2_d[i] = 0;
    end
    m_cnt = 0; m_flag = 0;
  endtask

  function automatic int qz(input int x, input int mode, output bit clip);
    int t;
    clip = 0;
    case (mode)
      0:       t = x >>> 4;
      1:       t = (x + 8) >>> 4;
      2:       t = x;
      default: t = 0;
    endcase
    if (mode == 1 || mode == 2) begin
      if (t > 2047)       begin t = 2047;  clip = 1; end
      else if (t < -2048) begin t = -2048; clip = 1; end
    end
    return t & 'hFFF;
  endfunction

  task automatic check_all();
    chk("out_valid", 32'(bus.out_valid), 32'(p2_v));
    chk("out_last",  32'(bus.out_last),  32'(p2_l));
    chk("out_ai",    32'(bus.out_ai),    p2_d[0]);
    chk("out_aq",    32'(bus.out_aq),    p2_d[1]);
    chk("out_bi",    32'(bus.out_bi),    p2_d[2]);
    chk("out_bq",    32'(bus.out_bq),    p2_d[3]);
    chk("clip_cnt",  32'(clip_cnt),      m_cnt);
    chk("clip_flag", 32'(clip_flag),     32'(m_flag));
  endtask

  // One clock cycle: drive inputs, advance the model across the edge, compare
  task automatic cyc(input bit v, input bit l,
                     input logic [15:0] a0, input logic [15:0] a1,
                     input logic [15:0] a2, input logic [15:0] a3,
                     input bit cv, input int cd, input int leg);
    int mode, sw, ng, ai, aq, bi, bq, t;
    int d[4];
    bit c0, c1, c2, c3, cl, upd;
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.in_ai     = a0;
    bus.in_aq     = a1;
    bus.in_bi     = a2;
    bus.in_bq     = a3;
    dspcmd_valid  = cv;
    dspcmd_data   = 28'(cd);
    dspcmd_legacy = 2'(leg);

    mode = m_active & 3;
    sw   = (m_active >> 2) & 1;
    ng   = (m_active >> 3) & 1;
    if (leg != 0) begin mode = 2; sw = 0; ng = 0; end
    ai = int'($signed(a0)); aq = int'($signed(a1));
    bi = int'($signed(a2)); bq = int'($signed(a3));
    if (sw != 0) begin
      t = ai; ai = aq; aq = t;
      t = bi; bi = bq; bq = t;
    end
    if (ng != 0) begin aq = -aq; bq = -bq; end
    d[0] = qz(ai, mode, c0);
    d[1] = qz(aq, mode, c1);
    d[2] = qz(bi, mode, c2);
    d[3] = qz(bq, mode, c3);
    cl = c0 | c1 | c2 | c3;

    @(posedge clk);
    #1;

    if (cv && ((cd & 16) != 0)) begin
      m_cnt = 0; m_flag = 0;
    end else if (p2_v && p2_c) begin
      if (m_cnt < CMAX) m_cnt++;
      m_flag = 1;
    end
    p2_v = p1_v; p2_l = p1_l; p2_c = p1_v && p1_c;
    if (p1_v) p2_d = p1_d;
    p1_v = v; p1_l = v && l; p1_c = cl;
    if (v) p1_d = d;
    upd = (!m_burst && !v) || (v && l);
    if (upd) m_active = m_shadow;
    if (cv) m_shadow = cd & 31;
    if (v) m_burst = !l;

    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, '0, '0, 0, 0, 0);
  endtask

  task automatic cmd(input int cd);
    cyc(0, 0, '0, '0, '0, '0, 1, cd, 0);
  endtask

  function automatic logic [15:0] rd();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'(32'h7FF0 + $urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic int rcmd();
    return int'($urandom_range(0, 15)) | (($urandom_range(0, 7) == 0) ? 16 : 0);
  endfunction

  function automatic int rleg();
    return ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_ai     = '0;
    bus.in_aq     = '0;
    bus.in_bi     = '0;
    bus.in_bq     = '0;
    dspcmd_valid  = 1'b0;
    dspcmd_data   = '0;
    dspcmd_legacy = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();

    // T1: mode 0 truncation
    cyc(1, 1, 16'h1234, 16'hFFF0, 16'h0000, 16'h0000, 0, 0, 0);
    idle(1);
    chk("T1_ai", 32'(bus.out_ai), 32'h123);
    chk("T1_aq", 32'(bus.out_aq), 32'hFFF);
    chk("T1_clip", 32'(clip_cnt), 32'h0);
    idle(2);

    // T2: mode 1 round with saturation
    cmd(1);
    idle(1);
    cyc(1, 0, 16'h7FF8, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    cyc(1, 1, 16'h0018, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    chk("T2_ai_sat", 32'(bus.out_ai), 32'h7FF);
    idle(1);
    chk("T2_ai_rnd", 32'(bus.out_ai), 32'h002);
    idle(2);
    chk("T2_cnt", 32'(clip_cnt), 32'h1);
    chk("T2_flag", 32'(clip_flag), 32'h1);

    // T3: mode 2 with Q negation, clip counter cleared by the same command
    cmd(2 | 8 | 16);
    idle(1);
    chk("T3_clr", 32'(clip_cnt), 32'h0);
    cyc(1, 1, 16'h0000, 16'h8000, 16'h0000, 16'h0005, 0, 0, 0);
    idle(1);
    chk("T3_aq", 32'(bus.out_aq), 32'h7FF);
    chk("T3_bq", 32'(bus.out_bq), 32'hFFB);
    idle(2);
    chk("T3_cnt", 32'(clip_cnt), 32'h1);

    // T4: mute command mid-burst takes effect on the next burst only
    cmd(16);
    idle(2);
    cyc(1, 0, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 0, 0, 0);
    cyc(1, 0, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 1, 3, 0);
    cyc(1, 0, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 0, 0, 0);
    cyc(1, 1, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 0, 0, 0);
    idle(1);
    chk("T4_unmuted", 32'(bus.out_ai), 32'h100);
    chk("T4_last", 32'(bus.out_last), 32'h1);
    idle(1);
    cyc(1, 1, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 0, 0, 0);
    idle(1);
    chk("T4_muted_v", 32'(bus.out_valid), 32'h1);
    chk("T4_muted", 32'({bus.out_ai, bus.out_bq}), 32'h0);
    idle(1);

    // T5: IQ swap
    cmd(4);
    idle(1);
    cyc(1, 1, 16'h0100, 16'h0200, 16'h0000, 16'h0000, 0, 0, 0);
    idle(1);
    chk("T5_ai", 32'(bus.out_ai), 32'h020);
    chk("T5_aq", 32'(bus.out_aq), 32'h010);
    idle(1);

    // Legacy override forces mode 2 regardless of active mute
    cmd(3);
    idle(1);
    cyc(1, 1, 16'h0123, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
    idle(1);
    chk("legacy_ai", 32'(bus.out_ai), 32'h123);
    idle(1);

    // Clip counter saturates at all-ones
    cmd(2 | 16);
    idle(1);
    for (int i = 0; i < 20; i++)
      cyc(1, i == 19, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    idle(3);
    chk("clip_sat", 32'(clip_cnt), CMAX);
    chk("clip_sat_flag", 32'(clip_flag), 32'h1);

    // T6: reset mid-burst
    cmd(2);
    idle(1);
    cyc(1, 0, 16'h1234, 16'h1111, 16'h2222, 16'h3333, 0, 0, 0);
    cyc(1, 0, 16'h7FFF, 16'h1111, 16'h2222, 16'h3333, 0, 0, 0);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    reset = 1'b1;
    #1;
    chk("T6_valid", 32'(bus.out_valid), 32'h0);
    chk("T6_data", 32'({bus.out_ai, bus.out_aq}), 32'h0);
    chk("T6_data_b", 32'({bus.out_bi, bus.out_bq}), 32'h0);
    chk("T6_cnt", 32'(clip_cnt), 32'h0);
    chk("T6_flag", 32'(clip_flag), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();
    cyc(1, 1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    idle(1);
    chk("T6_mode0", 32'(bus.out_ai), 32'h123);

    // Randomized bursts with commands landing in bursts or gaps
    for (int b = 0; b < 60; b++) begin
      int len, gap, cmd_at;
      len    = $urandom_range(1, 5);
      gap    = $urandom_range(0, 2);
      cmd_at = $urandom_range(0, len + 1);
      for (int k = 0; k < len; k++)
        cyc(1, k == len - 1, rd(), rd(), rd(), rd(), k == cmd_at, rcmd(), rleg());
      for (int g = 0; g < gap; g++)
        cyc(0, 0, '0, '0, '0, '0, (len + g) == cmd_at, rcmd(), 0);
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
